thread_regfile: RTL and testbench

//   Per-thread register file with write-back select: the stage directly upstream of the
//   per-thread ALU. One instance per thread.
//   - Supplies rs_data/rt_data operands, captured in REQUEST.
//   - Writes ALU, LSU or immediate results back in UPDATE.
//   - Holds the thread's NZP condition flags, taken from ALU compare results.
//   - Exposes read-only block/thread identity registers R13..R15.
//

---
 rtl/gpu_pkg.sv | 15 +
 rtl/thread_regfile_if.sv | 38 +++
 rtl/thread_regfile.sv | 67 ++++++
 tb/tb_thread_regfile.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core pipeline state encoding
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_t;

endpackage

// File: rtl/thread_regfile_if.sv
// rtl/thread_regfile_if.sv - operand/write-back bus between core control and a thread register file
interface thread_regfile_if
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic                  enable;
    core_state_t           core_state;
    logic [DATA_WIDTH-1:0] block_id;
    logic [AW-1:0]         rs_addr;
    logic [AW-1:0]         rt_addr;
    logic [AW-1:0]         rd_addr;
    logic                  reg_write_en;
    logic [1:0]            reg_input_mux;
    logic [DATA_WIDTH-1:0] immediate;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] lsu_out;
    logic                  nzp_write_en;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [2:0]            nzp;

    modport master (
        output enable, core_state, block_id, rs_addr, rt_addr, rd_addr,
               reg_write_en, reg_input_mux, immediate, alu_out, lsu_out, nzp_write_en,
        input  rs_data, rt_data, nzp
    );

    modport slave (
        input  enable, core_state, block_id, rs_addr, rt_addr, rd_addr,
               reg_write_en, reg_input_mux, immediate, alu_out, lsu_out, nzp_write_en,
        output rs_data, rt_data, nzp
    );

endinterface

// File: rtl/thread_regfile.sv
// rtl/thread_regfile.sv - per-thread register file with write-back select and NZP flags
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_REGS          = 16,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0
) (
    input  logic              clk,
    input  logic              rst,
    thread_regfile_if.slave   rf
);
    localparam int AW     = $clog2(NUM_REGS);
    localparam int DEPTH  = 1 << AW;
    localparam int NSTORE = NUM_REGS - 3;

    logic [DATA_WIDTH-1:0] regs     [NSTORE];
    logic [DATA_WIDTH-1:0] rd_table [DEPTH];
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_valid;
    logic                  do_write;

    // Full power-of-two read view: storage, then identity registers, zeros beyond NUM_REGS.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) rd_table[i] = '0;
        for (int i = 0; i < NSTORE; i++) rd_table[i] = regs[i];
        rd_table[NSTORE]     = rf.block_id;
        rd_table[NSTORE + 1] = DATA_WIDTH'(THREADS_PER_BLOCK);
        rd_table[NSTORE + 2] = DATA_WIDTH'(THREAD_ID);
    end

    always_comb begin
        wb_data  = '0;
        wb_valid = 1'b0;
        case (rf.reg_input_mux)
            2'b00:   begin wb_data = rf.alu_out;   wb_valid = 1'b1; end
            2'b01:   begin wb_data = rf.lsu_out;   wb_valid = 1'b1; end
            2'b10:   begin wb_data = rf.immediate; wb_valid = 1'b1; end
            default: begin wb_data = '0;           wb_valid = 1'b0; end
        endcase
    end

    assign do_write = rf.reg_write_en && wb_valid && (int'(rf.rd_addr) < NSTORE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTORE; i++) regs[i] <= '0;
            rf.rs_data <= '0;
            rf.rt_data <= '0;
            rf.nzp     <= 3'b000;
        end else if (rf.enable) begin
            case (rf.core_state)
                REQUEST: begin
                    rf.rs_data <= rd_table[rf.rs_addr];
                    rf.rt_data <= rd_table[rf.rt_addr];
                end
                UPDATE: begin
                    if (do_write) regs[rf.rd_addr] <= wb_data;
                    if (rf.nzp_write_en) rf.nzp <= rf.alu_out[2:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
// tb/tb_thread_regfile.sv - self-checking bench for thread_regfile
module tb_thread_regfile;
    import gpu_pkg::*;

    localparam int DW  = 8;
    localparam int NR  = 16;
    localparam int TPB = 4;
    localparam int TID = 5;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    thread_regfile_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    thread_regfile #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .THREADS_PER_BLOCK(TPB), .THREAD_ID(TID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: thirteen storage registers plus the three visible outputs.
    logic [DW-1:0] m_regs [13];
    logic [DW-1:0] m_rs, m_rt;
    logic [2:0]    m_nzp;

    function automatic logic [DW-1:0] mread(input logic [3:0] a);
        if (a < 4'd13) return m_regs[a];
        if (a == 4'd13) return bus.block_id;
        if (a == 4'd14) return DW'(TPB);
        return DW'(TID);
    endfunction

    task automatic tick();
        logic [DW-1:0] n_regs [13];
        logic [DW-1:0] n_rs, n_rt;
        logic [2:0]    n_nzp;
        n_regs = m_regs;
        n_rs   = m_rs;
        n_rt   = m_rt;
        n_nzp  = m_nzp;
        if (rst) begin
            for (int i = 0; i < 13; i++) n_regs[i] = '0;
            n_rs  = '0;
            n_rt  = '0;
            n_nzp = 3'b000;
        end else if (bus.enable) begin
            if (bus.core_state == REQUEST) begin
                n_rs = mread(bus.rs_addr);
                n_rt = mread(bus.rt_addr);
            end
            if (bus.core_state == UPDATE) begin
                if (bus.reg_write_en && bus.rd_addr < 4'd13) begin
                    if (bus.reg_input_mux == 2'b00) n_regs[bus.rd_addr] = bus.alu_out;
                    if (bus.reg_input_mux == 2'b01) n_regs[bus.rd_addr] = bus.lsu_out;
                    if (bus.reg_input_mux == 2'b10) n_regs[bus.rd_addr] = bus.immediate;
                end
                if (bus.nzp_write_en) n_nzp = bus.alu_out[2:0];
            end
        end
        @(posedge clk);
        m_regs = n_regs;
        m_rs   = n_rs;
        m_rt   = n_rt;
        m_nzp  = n_nzp;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_rs_data", bus.rs_data, m_rs);
            check("model_rt_data", bus.rt_data, m_rt);
            check("model_nzp", DW'(bus.nzp), DW'(m_nzp));
        end
    end

    task automatic idle_inputs();
        bus.core_state    = IDLE;
        bus.reg_write_en  = 1'b0;
        bus.nzp_write_en  = 1'b0;
        bus.reg_input_mux = 2'b00;
    endtask

    task automatic request(input logic [3:0] rs, input logic [3:0] rt);
        idle_inputs();
        bus.core_state = REQUEST;
        bus.rs_addr    = rs;
        bus.rt_addr    = rt;
        tick();
        idle_inputs();
    endtask

    task automatic update(input logic [3:0] rd, input logic [1:0] mux, input logic [DW-1:0] val,
                          input logic wen, input logic nzpw);
        idle_inputs();
        bus.core_state    = UPDATE;
        bus.rd_addr       = rd;
        bus.reg_input_mux = mux;
        bus.reg_write_en  = wen;
        bus.nzp_write_en  = nzpw;
        bus.alu_out       = val;
        bus.lsu_out       = val;
        bus.immediate     = val;
        tick();
        idle_inputs();
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b1;
        bus.block_id = '0;
        bus.rs_addr  = '0;
        bus.rt_addr  = '0;
        bus.rd_addr  = '0;
        bus.alu_out  = '0;
        bus.lsu_out  = '0;
        bus.immediate = '0;
        idle_inputs();
        for (int i = 0; i < 13; i++) m_regs[i] = 'x;
        m_rs = 'x; m_rt = 'x; m_nzp = 'x;
        @(negedge clk);
        tick();
        rst    = 1'b0;
        chk_on = 1'b1;

        // 1: reset state
        request(4'd0, 4'd5);
        check("reset_rs", bus.rs_data, 8'h00);
        check("reset_rt", bus.rt_data, 8'h00);
        check("reset_nzp", DW'(bus.nzp), 8'h00);

        // 2: immediate write then read back
        update(4'd3, 2'b10, 8'h2A, 1'b1, 1'b0);
        bus.core_state = EXECUTE; tick(); idle_inputs();
        request(4'd3, 4'd0);
        check("imm_r3", bus.rs_data, 8'h2A);

        // 3: identity registers, write to R14 dropped
        update(4'd14, 2'b00, 8'hFF, 1'b1, 1'b0);
        bus.block_id = 8'd7;
        request(4'd14, 4'd13);
        check("r14_tpb", bus.rs_data, 8'd4);
        check("r13_block", bus.rt_data, 8'd7);
        request(4'd15, 4'd3);
        check("r15_tid", bus.rs_data, 8'd5);

        // 4: simultaneous register and nzp write
        update(4'd2, 2'b00, 8'h04, 1'b1, 1'b1);
        check("cmp_nzp", DW'(bus.nzp), 8'h04);
        request(4'd2, 4'd3);
        check("cmp_r2", bus.rs_data, 8'h04);
        update(4'd0, 2'b01, 8'h5C, 1'b1, 1'b0);
        update(4'd12, 2'b10, 8'h99, 1'b1, 1'b0);
        request(4'd0, 4'd12);
        check("lsu_r0", bus.rs_data, 8'h5C);
        check("imm_r12", bus.rt_data, 8'h99);

        // 5: disabled thread freezes everything
        bus.enable = 1'b0;
        request(4'd13, 4'd14);
        update(4'd3, 2'b10, 8'h11, 1'b1, 1'b1);
        check("dis_rs_hold", bus.rs_data, 8'h5C);
        check("dis_nzp_hold", DW'(bus.nzp), 8'h04);
        bus.enable = 1'b1;
        request(4'd3, 4'd2);
        check("dis_r3_kept", bus.rs_data, 8'h2A);

        // Every state with write strobes asserted; only UPDATE may act.
        for (int s = 0; s < 8; s++) begin
            bus.core_state    = core_state_t'(3'(s));
            bus.rs_addr       = 4'd4;
            bus.rt_addr       = 4'd3;
            bus.rd_addr       = 4'd4;
            bus.reg_input_mux = 2'b10;
            bus.immediate     = 8'h30 + 8'(s);
            bus.alu_out       = 8'h01;
            bus.reg_write_en  = 1'b1;
            bus.nzp_write_en  = 1'b1;
            tick();
        end
        idle_inputs();
        request(4'd4, 4'd3);
        check("sweep_r4", bus.rs_data, 8'h36);

        // 6: reserved mux, then reset mid-instruction
        update(4'd3, 2'b11, 8'h55, 1'b1, 1'b0);
        request(4'd3, 4'd3);
        check("mux11_no_write", bus.rs_data, 8'h2A);
        update(4'd1, 2'b10, 8'h77, 1'b1, 1'b0);
        request(4'd1, 4'd1);
        check("r1_written", bus.rs_data, 8'h77);
        bus.core_state = EXECUTE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("rst_nzp", DW'(bus.nzp), 8'h00);
        request(4'd1, 4'd3);
        check("rst_r1", bus.rs_data, 8'h00);
        check("rst_r3", bus.rt_data, 8'h00);

        chk_on = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
